// File: rtl/dds_lut_loader.sv
// Streams 16-bit sine samples into the DDS lookup table through its write port,
// one setup/strobe/hold sequence per entry, and enables the DDS once the table is full.
module dds_lut_loader #(
  parameter int AddrWidth   = 16,
  parameter int SetupCycles = 1,
  parameter int HoldCycles  = 1
) (
  input  logic               AXI_clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               s_valid,
  input  logic signed [15:0] s_data,
  output logic               s_ready,
  output logic               LUTWriteEn,
  output logic [31:0]        LUTAddress,
  output logic [31:0]        LUTData,
  output logic               dds_en,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  localparam int CntW  = AddrWidth + 1;
  localparam int PhMax = (SetupCycles > HoldCycles) ? SetupCycles : HoldCycles;
  localparam int PhW   = (PhMax > 1) ? $clog2(PhMax) : 1;

  localparam logic [CntW-1:0] LastIdx   = {1'b0, {AddrWidth{1'b1}}};
  localparam logic [PhW-1:0]  SetupLast = PhW'(SetupCycles - 1);
  localparam logic [PhW-1:0]  HoldLast  = PhW'(HoldCycles - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  state_t          state;
  logic [CntW-1:0] cnt;
  logic [PhW-1:0]  phase;

  function automatic logic [31:0] lut_addr(input logic [AddrWidth-1:0] idx);
    return 32'(idx);
  endfunction

  function automatic logic [31:0] lut_word(input logic signed [15:0] sample);
    return {16'h0000, sample};
  endfunction

  always_ff @(posedge AXI_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      phase      <= '0;
      s_ready    <= 1'b0;
      LUTWriteEn <= 1'b0;
      LUTAddress <= '0;
      LUTData    <= '0;
      dds_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else if (abort && state != IDLE) begin
      // Abort drops everything at once; a strobe in flight is cut, never stretched.
      state      <= IDLE;
      s_ready    <= 1'b0;
      LUTWriteEn <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dds_en     <= 1'b0;
      aborted    <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // abort shares priority here so a simultaneous start is dropped
          if (start && !abort) begin
            state   <= FETCH;
            cnt     <= '0;
            dds_en  <= 1'b0;
            aborted <= 1'b0;
            busy    <= 1'b1;
            s_ready <= 1'b1;
          end
        end
        FETCH: begin
          if (s_valid && s_ready) begin
            LUTData    <= lut_word(s_data);
            LUTAddress <= lut_addr(cnt[AddrWidth-1:0]);
            s_ready    <= 1'b0;
            phase      <= '0;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (phase == SetupLast) begin
            LUTWriteEn <= 1'b1;
            state      <= STROBE;
          end else begin
            phase <= phase + PhW'(1);
          end
        end
        STROBE: begin
          LUTWriteEn <= 1'b0;
          phase      <= '0;
          state      <= HOLD;
        end
        HOLD: begin
          if (phase == HoldLast) begin
            if (cnt == LastIdx) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cnt     <= cnt + CntW'(1);
              s_ready <= 1'b1;
              state   <= FETCH;
            end
          end else begin
            phase <= phase + PhW'(1);
          end
        end
        DONE: begin
          dds_en <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_lut_loader.sv
// Bench for dds_lut_loader: two instances (1/1 and 3/2 setup/hold) share one
// stimulus source and one strobe monitor through an output mux.
module tb_dds_lut_loader;

  localparam int AW      = 4;
  localparam int ENTRIES = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, start, abort, s_valid, sel;
  logic signed [15:0] s_data;
  logic               start_a, start_b;
  logic               s_ready_a, we_a, dds_en_a, busy_a, done_a, aborted_a;
  logic               s_ready_b, we_b, dds_en_b, busy_b, done_b, aborted_b;
  logic [31:0]        addr_a, data_a, addr_b, data_b;
  logic               s_ready, we, dds_en, busy, done, aborted;
  logic [31:0]        addr, data;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign s_ready = sel ? s_ready_b : s_ready_a;
  assign we      = sel ? we_b      : we_a;
  assign addr    = sel ? addr_b    : addr_a;
  assign data    = sel ? data_b    : data_a;
  assign dds_en  = sel ? dds_en_b  : dds_en_a;
  assign busy    = sel ? busy_b    : busy_a;
  assign done    = sel ? done_b    : done_a;
  assign aborted = sel ? aborted_b : aborted_a;

  dds_lut_loader #(.AddrWidth(AW), .SetupCycles(1), .HoldCycles(1)) dut (
    .AXI_clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_a),
    .LUTWriteEn(we_a), .LUTAddress(addr_a), .LUTData(data_a),
    .dds_en(dds_en_a), .busy(busy_a), .done(done_a), .aborted(aborted_a));

  dds_lut_loader #(.AddrWidth(AW), .SetupCycles(3), .HoldCycles(2)) dut_t (
    .AXI_clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_b),
    .LUTWriteEn(we_b), .LUTAddress(addr_b), .LUTData(data_b),
    .dds_en(dds_en_b), .busy(busy_b), .done(done_b), .aborted(aborted_b));

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  typedef struct {
    bit sel;
    int gap_at;
    int gap_len;
    bit ign;
    int period;
    int setup;
    int done_k;
  } vec_t;

  exp_t q[$];
  exp_t mon_e;
  vec_t tbl[4];

  int cmp_cnt = 0;
  int err_cnt = 0;
  int n, gap_at, gap_len, gap_rem;
  int strobe_cnt, done_cnt, last_we, exp_per, exp_setup;
  int cyc = 0;
  int since_chg = 0;
  logic [31:0] prev_addr, prev_data;
  logic prev_we, prev_sready, prev_sel;
  bit acc, stall;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Sample source: pushes the expected LUT write for every accepted sample.
  always begin
    @(negedge clk);
    acc   = s_valid && s_ready && rst_n;
    stall = !s_valid && s_ready && (gap_rem > 0);
    @(posedge clk);
    #1;
    if (acc) begin
      q.push_back('{32'(n), 32'h1000 + 32'(n)});
      n++;
      s_data = 16'(32'h1000 + 32'(n));
      if (n == gap_at) begin
        s_valid = 1'b0;
        gap_rem = gap_len;
      end
    end
    if (stall) begin
      gap_rem--;
      if (gap_rem == 0) s_valid = 1'b1;
    end
  end

  // Strobe monitor
  always @(negedge clk) begin
    cyc++;
    if (!rst_n || sel !== prev_sel) begin
      since_chg = 0;
    end else begin
      if (addr !== prev_addr || data !== prev_data) begin
        check("change_only_after_accept", prev_sready, 1);
        since_chg = 0;
      end else begin
        since_chg++;
      end
      if (we) begin
        check("we_single_cycle", prev_we, 0);
        check("strobe_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          check("strobe_addr", addr, mon_e.a);
          check("strobe_data", data, mon_e.d);
        end
        check("setup_cycles", since_chg, exp_setup);
        if (last_we >= 0)
          check("strobe_period", cyc - last_we, exp_per + ((strobe_cnt == gap_at) ? gap_len : 0));
        last_we = cyc;
        strobe_cnt++;
      end
      if (done) done_cnt++;
    end
    prev_addr   = addr;
    prev_data   = data;
    prev_we     = we;
    prev_sready = s_ready;
    prev_sel    = sel;
  end

  task automatic begin_load(input vec_t v);
    sel        = v.sel;
    q.delete();
    n          = 0;
    gap_at     = v.gap_at;
    gap_len    = v.gap_len;
    gap_rem    = 0;
    strobe_cnt = 0;
    done_cnt   = 0;
    last_we    = -1;
    exp_per    = v.period;
    exp_setup  = v.setup;
    s_data     = 16'h1000;
    s_valid    = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b1;
  endtask

  task automatic run_load(input vec_t v);
    int k;
    bit seen;
    bit fired;
    begin_load(v);
    k = 0;
    seen = 0;
    fired = 0;
    while (!seen && k < 2000) begin
      @(negedge clk);
      #1;
      k++;
      start = 1'b0;
      if (k == 1) begin
        check("start_busy", busy, 1);
        check("start_sready", s_ready, 1);
        check("start_dds_en_low", dds_en, 0);
        check("start_clears_aborted", aborted, 0);
      end
      if (v.ign && !fired && strobe_cnt == 2 && s_ready) begin
        start = 1'b1;
        fired = 1;
      end
      if (busy) check("dds_en_low_in_load", dds_en, 0);
      if (done) begin
        seen = 1;
        check("done_latency", k, v.done_k);
        if (v.ign) start = 1'b1;
      end
    end
    check("done_seen", seen, 1);
    @(negedge clk);
    #1;
    start = 1'b0;
    check("post_done_dds_en", dds_en, 1);
    check("post_done_busy", busy, 0);
    check("done_one_cycle", done, 0);
    check("post_done_sready", s_ready, 0);
    repeat (5) @(negedge clk);
    #1;
    check("strobe_count", strobe_cnt, ENTRIES);
    check("done_count", done_cnt, 1);
    check("queue_drained", q.size(), 0);
    check("idle_busy", busy, 0);
    s_valid = 1'b0;
  endtask

  initial begin
    bit hit;
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    s_valid = 1'b0;
    sel     = 1'b0;
    s_data  = '0;
    gap_at  = -1;
    gap_len = 0;
    gap_rem = 0;
    n = 0;
    last_we = -1;
    exp_per = 4;
    exp_setup = 1;
    strobe_cnt = 0;
    done_cnt = 0;

    // {sel, gap_at, gap_len, ign, period, setup, done_k}
    tbl[0] = '{1'b0, -1, 0, 1'b0, 4, 1, 65};
    tbl[1] = '{1'b0,  5, 7, 1'b0, 4, 1, 72};
    tbl[2] = '{1'b1, -1, 0, 1'b0, 7, 3, 113};
    tbl[3] = '{1'b0, -1, 0, 1'b1, 4, 1, 65};

    repeat (3) @(negedge clk);
    #1;
    check("rst_we", we, 0);
    check("rst_addr", addr, 0);
    check("rst_data", data, 0);
    check("rst_sready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dds_en", dds_en, 0);
    check("rst_aborted", aborted, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    for (int i = 0; i < 4; i++) run_load(tbl[i]);

    // Abort during the strobe of entry 9
    begin_load(tbl[0]);
    hit = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      start = 1'b0;
      if (we && addr == 32'd9) begin
        abort = 1'b1;
        hit = 1;
        break;
      end
    end
    check("abort_point_reached", hit, 1);
    @(negedge clk);
    #1;
    abort = 1'b0;
    check("abort_we", we, 0);
    check("abort_busy", busy, 0);
    check("abort_aborted", aborted, 1);
    check("abort_dds_en", dds_en, 0);
    check("abort_sready", s_ready, 0);
    check("abort_no_done", done, 0);
    repeat (6) @(negedge clk);
    #1;
    check("abort_done_count", done_cnt, 0);
    check("abort_strobe_count", strobe_cnt, 10);
    check("abort_queue", q.size(), 0);
    s_valid = 1'b0;
    run_load(tbl[0]);

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_sready", s_ready, 0);
    check("start_abort_dds_en", dds_en, 1);
    check("start_abort_aborted", aborted, 0);

    // Asynchronous reset during SETUP of entry 3
    begin_load(tbl[0]);
    hit = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      start = 1'b0;
      if (strobe_cnt == 3 && addr == 32'd3 && !we && !s_ready) begin
        hit = 1;
        break;
      end
    end
    check("reset_point_reached", hit, 1);
    rst_n = 1'b0;
    #1;
    check("arst_we", we, 0);
    check("arst_addr", addr, 0);
    check("arst_data", data, 0);
    check("arst_sready", s_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_dds_en", dds_en, 0);
    check("arst_aborted", aborted, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("post_reset_busy", busy, 0);
    check("post_reset_sready", s_ready, 0);
    check("post_reset_no_strobe", strobe_cnt, 3);
    check("post_reset_no_done", done_cnt, 0);
    s_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
